div_seq: RTL
============

# div_seq

Sequential unsigned restoring divider built around one shared `subtract` instance. It produces one quotient bit per clock. Operands are captured on a start strobe and results are held until the next operation. It is the multi-cycle divide unit that sits beside the combinational add/subtract datapath, and it uses the subtractor's borrow output (`o_carry`) as its compare decision.

## Interface
Parameters:
- `N`, default 8: operand, quotient and remainder width in bits; must be ≥ 2.

Ports:
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: reset; synchronous, active-low.
- `i_start`, input, 1: operation request; sampled only in IDLE.
- `i_dividend`, input, N: unsigned dividend; captured when `i_start` is accepted.
- `i_divisor`, input, N: unsigned divisor; captured when `i_start` is accepted.
- `o_busy`, output, 1: high while in CALC.
- `o_done`, output, 1: one-cycle pulse in DONE.
- `o_quotient`, output, N: quotient register.
- `o_remainder`, output, N: remainder register.
- `o_div_zero`, output, 1: the last accepted divisor was 0.

## Operation
- Internal state:
  - R: N-bit remainder.
  - Q: N-bit shift register; holds the dividend, then the quotient.
  - D: N-bit captured divisor.
  - cnt: bit counter, width $clog2(N+1).
- State IDLE:
  - If `i_start`=1 and `i_divisor`≠0: load R=0, Q=`i_dividend`, D=`i_divisor`, cnt=N, clear `o_div_zero`, go to CALC.
  - If `i_start`=1 and `i_divisor`=0: load Q=all-ones, R=`i_dividend`, set `o_div_zero`=1, go to DONE.
  - Otherwise stay in IDLE.
- State CALC, one iteration per cycle:
  - Subtractor inputs (width N+1): a = {R, Q[N-1]}, b = {1'b0, D}.
  - If borrow=1: R = a[N-1:0] and Q = {Q[N-2:0], 1'b0}.
  - If borrow=0: R = diff[N-1:0] and Q = {Q[N-2:0], 1'b1}.
  - cnt decrements by 1; when cnt reaches 1 in this cycle, go to DONE.
- State DONE: assert `o_done` for this cycle only, then go to IDLE.
- Result outputs:
  - `o_quotient`, `o_remainder` and `o_div_zero` are direct register outputs.
  - They are valid from the DONE cycle onward and hold until the next accepted start.
  - Their contents during CALC are intermediate and undefined for consumers.
- Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor, for every divisor ≠ 0.
- `i_start` is ignored in CALC and DONE; it is not queued.
- Reset (`i_rst_n`=0 at a rising edge) forces the following, from any state including mid-CALC:
  - State = IDLE.
  - R=0, Q=0, D=0, cnt=0.
  - `o_busy`=0, `o_done`=0, `o_quotient`=0, `o_remainder`=0, `o_div_zero`=0.
  - No result is produced for an aborted operation.
- Reset has priority over `i_start` in the same cycle.

## Timing
- Accepted start at edge k (state IDLE before the edge):
  - CALC occupies cycles k+1 through k+N, with `o_busy`=1.
  - DONE occupies cycle k+N+1, with `o_done`=1 and `o_busy`=0.
  - State returns to IDLE at cycle k+N+2.
- Divide-by-zero start at edge k: DONE occupies cycle k+1; `o_busy` never rises.
- Throughput: one division per N+2 cycles. A start held high through DONE is accepted at the first IDLE cycle, so the fastest back-to-back spacing is N+2 cycles.
- Combinational path per cycle: one (N+1)-bit subtract feeding a 2:1 mux into R. No other long paths.
- `o_done` and `o_busy` are decoded from registered state only; they have no combinational dependence on inputs.

## Structure
- Package `div_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t`.
- Sub-module: exactly one `subtract` instance with parameter N = N+1.
  - Connect its `o_out` and `o_carry` directly.
  - No other arithmetic operators in this block except the cnt decrement.
- Datapath registers and the FSM live in one `always_ff` block. Next-state and subtractor-operand logic live in `always_comb`.

## Test plan
All cases use N=8 unless stated otherwise.
- 100 / 7: start at edge 0 → `o_busy` high for cycles 1–8; `o_done` at cycle 9 with quotient=14, remainder=2, `o_div_zero`=0.
- 255 / 1 → quotient=255, remainder=0. Then 5 / 9 → quotient=0, remainder=5. Each in N+2 cycles; the outputs of the first case hold until the second start.
- 42 / 0 → `o_done` at cycle 1 with quotient=255, remainder=42, `o_div_zero`=1, `o_busy` never high. A following 42 / 6 → quotient=7, remainder=0, `o_div_zero`=0.
- Pulse `i_start` with 9 / 3 in cycle 4 of a 200 / 13 operation → ignored. The operation completes with quotient=15, remainder=5, and no second `o_done`.
- Assert `i_rst_n`=0 in cycle 5 of 200 / 13 → all outputs 0 and state IDLE on the next cycle, with no `o_done`. A new 200 / 13 then completes correctly.
- Random sweep: N=8 exhaustive over all divisors 1–255 with random dividends, plus N=16 random, with back-to-back starts held high. Check the quotient·divisor + remainder identity, remainder < divisor, and the N+2 cycle spacing.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared FSM state type for the sequential restoring divider
package div_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_seq_subtract.sv
// subtract: unsigned N-bit subtractor; i_a, i_b operands -> o_out = i_a - i_b, o_carry = borrow (i_a < i_b)
module subtract #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_out,
  output logic         o_carry
);
  assign {o_carry, o_out} = {1'b0, i_a} - {1'b0, i_b};
endmodule

// File: rtl/div_seq.sv
// div_seq: one-bit-per-cycle unsigned restoring divider; i_clk/i_rst_n, i_start+i_dividend/i_divisor in, o_busy/o_done/o_quotient/o_remainder/o_div_zero out
module div_seq
  import div_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_zero
);
  localparam int CW = $clog2(N + 1);
  div_state_t r_state;
  div_state_t w_next;
  logic [N-1:0] r_r;
  logic [N-1:0] r_q;
  logic [N-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic r_busy;
  logic r_done;
  logic r_dz;
  logic [N:0] w_a;
  logic [N:0] w_b;
  logic [N:0] w_diff;
  logic w_borrow;
  logic w_unused;
  always_comb begin
    w_a = {r_r, r_q[N-1]};
    w_b = {1'b0, r_d};
    w_next = div_state_t'(r_state == IDLE ? (i_start ? (i_divisor == '0 ? DONE : CALC) : IDLE)
           : r_state == CALC ? (r_cnt == CW'(1) ? DONE : CALC) : IDLE);
  end
  subtract #(.N(N + 1)) u_sub (
    .i_a    (w_a),
    .i_b    (w_b),
    .o_out  (w_diff),
    .o_carry(w_borrow)
  );
  // top diff bit is always 0 when it is selected (no borrow), so it never reaches R
  assign w_unused = w_diff[N];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_r <= '0;
      r_q <= '0;
      r_d <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy <= w_next == CALC;
      r_done <= w_next == DONE;
      if (r_state == IDLE && i_start) begin
        r_dz <= i_divisor == '0;
        r_q <= i_divisor == '0 ? '1 : i_dividend;
        r_r <= i_divisor == '0 ? i_dividend : '0;
        r_d <= i_divisor;
        r_cnt <= CW'(N);
      end else if (r_state == CALC) begin
        r_r <= w_borrow ? w_a[N-1:0] : w_diff[N-1:0];
        r_q <= {r_q[N-2:0], ~w_borrow};
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quotient = r_q;
  assign o_remainder = r_r;
  assign o_div_zero = r_dz;
endmodule
